// File: rtl/cpu_pkg.sv
// Shared types and instruction field positions for the 16-bit toy CPU control path.
package cpu_pkg;

    localparam int IR_W   = 16;
    localparam int REG_AW = 4;
    localparam int IMM_W  = 8;
    localparam int TGT_W  = 5;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int LI_BIT = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;
    localparam int TGT_HI = 12;
    localparam int TGT_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        OP_STORE = 3'b000,
        OP_LOAD  = 3'b001,
        OP_ADD   = 3'b010,
        OP_BEQ   = 3'b101,
        OP_STOP  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } seq_state_t;

    // WD_NONE drives a zero write-data bus for ops that do not write the RF.
    typedef enum logic [1:0] {
        WD_NONE,
        WD_IMM,
        WD_DM,
        WD_ALU
    } wd_sel_t;

    typedef struct packed {
        logic              rf_we;
        logic              dm_we;
        logic              illegal;
        logic              is_beq;
        logic              is_stop;
        wd_sel_t           wd_sel;
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic [REG_AW-1:0] wa;
        logic [REG_AW-1:0] dm_addr;
        logic [IMM_W-1:0]  imm;
        logic [TGT_W-1:0]  target;
    } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of the instruction register into addresses,
// write-data select and write/control flags.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output decode_t         dec
);

    logic [2:0] op_bits;

    assign op_bits = ir[OP_HI:OP_LO];

    // NOTE: every field gets a default before the case so no path can infer a latch.
    always_comb begin
        dec         = '0;
        dec.wd_sel  = WD_NONE;
        dec.ra1     = ir[RS_HI:RS_LO];
        dec.ra2     = ir[RT_HI:RT_LO];
        dec.wa      = ir[RD_HI:RD_LO];
        dec.dm_addr = ir[RS_HI:RS_LO];
        dec.imm     = ir[IMM_HI:IMM_LO];
        dec.target  = ir[TGT_HI:TGT_LO];

        case (opcode_t'(op_bits))
            OP_STORE: begin
                // Port A supplies the DM write data, so it reads the source register.
                dec.ra1   = ir[RT_HI:RT_LO];
                dec.dm_we = 1'b1;
            end
            OP_LOAD: begin
                dec.rf_we = 1'b1;
                if (ir[LI_BIT]) begin
                    dec.wd_sel = WD_IMM;
                end else begin
                    dec.wa     = ir[RT_HI:RT_LO];
                    dec.wd_sel = WD_DM;
                end
            end
            OP_ADD: begin
                dec.rf_we  = 1'b1;
                dec.wd_sel = WD_ALU;
            end
            OP_BEQ: begin
                dec.is_beq = 1'b1;
            end
            OP_STOP: begin
                dec.is_stop = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer: owns PC, IR and the retired counter,
// and strobes the RF/DM write ports for exactly the EXEC cycle.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    output logic [PC_W-1:0]   pc,
    input  logic [IR_W-1:0]   instr,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [REG_AW-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_rd,
    output logic              dm_we,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    seq_state_t      state;
    seq_state_t      next_state;
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] next_pc;
    decode_t         dec;

    instr_decoder u_decoder (
        .ir  (ir),
        .dec (dec)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (restart) begin
                    next_state = IDLE;
                end else if (run || step) begin
                    next_state = FETCH;
                end
            end
            FETCH:  next_state = DECODE;
            DECODE: next_state = EXEC;
            EXEC: begin
                if (dec.is_stop) begin
                    next_state = HALT;
                end else if (run) begin
                    next_state = FETCH;
                end else begin
                    next_state = IDLE;
                end
            end
            HALT: begin
                if (restart) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes derive only from registered state and IR, so reset clears them at once.
    always_comb begin
        rf_we   = 1'b0;
        dm_we   = 1'b0;
        illegal = 1'b0;
        halted  = (state == HALT);
        if (state == EXEC) begin
            rf_we   = dec.rf_we;
            dm_we   = dec.dm_we;
            illegal = dec.illegal;
        end
    end

    always_comb begin
        case (dec.wd_sel)
            WD_IMM:  rf_wd = DATA_W'(dec.imm);
            WD_DM:   rf_wd = dm_rd;
            WD_ALU:  rf_wd = rf_rd1 + rf_rd2;
            default: rf_wd = '0;
        endcase
    end

    always_comb begin
        if (dec.is_stop) begin
            next_pc = pc;
        end else if (dec.is_beq && (rf_rd1 == rf_rd2)) begin
            next_pc = PC_W'(dec.target);
        end else begin
            next_pc = pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
        end else begin
            if (state == FETCH) begin
                ir <= instr;
            end
            if (state == EXEC) begin
                pc      <= next_pc;
                retired <= retired + CNT_W'(1);
            end else if (restart && (state == IDLE || state == HALT)) begin
                pc <= '0;
            end
        end
    end

    assign rf_ra1  = dec.ra1;
    assign rf_ra2  = dec.ra2;
    assign rf_wa   = dec.wa;
    assign dm_addr = dec.dm_addr;

endmodule
